// File: rtl/dp_sequencer.sv
// dp_sequencer: accepts 16-bit instructions over valid/ready and steps each one
// through register read, execute and write-back for the Datapath.
module dp_sequencer #(
    parameter int INST_W  = 16,
    parameter int RADDR_W = 4,
    parameter int CTRL_W  = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INST_W-1:0]  inst,
    input  logic               inst_valid,
    output logic               inst_ready,
    output logic [CTRL_W-1:0]  dp_ctrl,
    output logic [RADDR_W-1:0] addr1,
    output logic [RADDR_W-1:0] addr2,
    output logic               rd1,
    output logic               rd2,
    output logic [RADDR_W-1:0] wr_addr,
    output logic               wr1,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retire_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        HALTED
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              wr;
        logic              legal;
        logic              halt;
    } dec_t;

    state_t             state;
    dec_t               dn;
    dec_t               dec_q;
    logic [RADDR_W-1:0] rd_q;
    logic [3:0]         op;
    logic               use_a;
    logic               use_b;

    assign op = inst[15:12];

    // ALU-style ops read both operands; STORE_OUT reads only rs1
    assign use_b = (op >= 4'h1) && (op <= 4'h4);
    assign use_a = use_b || (op == 4'h6);

    always_comb begin
        dn       = '0;
        dn.legal = 1'b1;
        case (op)
            4'h0: dn.ctrl = '0;
            4'h1: begin dn.ctrl = CTRL_W'(1);      dn.wr = 1'b1; end
            4'h2: begin dn.ctrl = CTRL_W'(1) << 1; dn.wr = 1'b1; end
            4'h3: begin dn.ctrl = CTRL_W'(1) << 2; dn.wr = 1'b1; end
            4'h4: begin dn.ctrl = CTRL_W'(1) << 3; dn.wr = 1'b1; end
            4'h5: begin dn.ctrl = CTRL_W'(1) << 4; dn.wr = 1'b1; end
            4'h6: dn.ctrl = CTRL_W'(1) << 5;
            4'hF: dn.halt = 1'b1;
            default: dn.legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dec_q      <= '0;
            rd_q       <= '0;
            inst_ready <= 1'b0;
            dp_ctrl    <= '0;
            addr1      <= '0;
            addr2      <= '0;
            rd1        <= 1'b0;
            rd2        <= 1'b0;
            wr_addr    <= '0;
            wr1        <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_valid && inst_ready) begin
                        dec_q      <= dn;
                        rd_q       <= RADDR_W'(inst[11:8]);
                        inst_ready <= 1'b0;
                        rd1        <= use_a;
                        rd2        <= use_b;
                        if (use_a) addr1 <= RADDR_W'(inst[7:4]);
                        if (use_b) addr2 <= RADDR_W'(inst[3:0]);
                        state      <= READ;
                    end else begin
                        inst_ready <= 1'b1;
                    end
                end
                READ: begin
                    rd1 <= 1'b0;
                    rd2 <= 1'b0;
                    if (dec_q.halt) begin
                        halted     <= 1'b1;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                        state      <= HALTED;
                    end else begin
                        dp_ctrl <= dec_q.ctrl;
                        if (!dec_q.legal) illegal <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    dp_ctrl <= '0;
                    wr1     <= dec_q.wr;
                    if (dec_q.wr) wr_addr <= rd_q;
                    state   <= WB;
                end
                WB: begin
                    wr1        <= 1'b0;
                    inst_ready <= 1'b1;
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    state      <= IDLE;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_dp_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [5:0]  dp_ctrl;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic        rd1;
    logic        rd2;
    logic [3:0]  wr_addr;
    logic        wr1;
    logic        halted;
    logic        illegal;
    logic [15:0] retire_cnt;

    int checks   = 0;
    int failures = 0;

    dp_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .dp_ctrl    (dp_ctrl),
        .addr1      (addr1),
        .addr2      (addr2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wr_addr    (wr_addr),
        .wr1        (wr1),
        .halted     (halted),
        .illegal    (illegal),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, inst_ready}, 0);
        chk({tag, "_ctrl"}, {26'd0, dp_ctrl}, 0);
        chk({tag, "_addr"}, {20'd0, addr1, addr2, wr_addr}, 0);
        chk({tag, "_strb"}, {28'd0, rd1, rd2, wr1, halted}, 0);
        chk({tag, "_ill"}, {31'd0, illegal}, 0);
        chk({tag, "_cnt"}, {16'd0, retire_cnt}, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        inst       = 16'h0000;
        inst_valid = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        // ADD r3 = r1 + r2
        rst_n      = 1'b1;
        inst       = 16'h1312;
        inst_valid = 1'b1;
        tick();
        chk("add_ready_rise", {31'd0, inst_ready}, 1);
        chk("add_no_early_rd", {31'd0, rd1}, 0);
        tick();
        inst_valid = 1'b0;
        chk("add_e0_ready", {31'd0, inst_ready}, 0);
        chk("add_e0_rd", {30'd0, rd1, rd2}, 2'b11);
        chk("add_e0_addr", {24'd0, addr1, addr2}, 8'h12);
        chk("add_e0_ctrl", {26'd0, dp_ctrl}, 0);
        tick();
        chk("add_e1_rd", {30'd0, rd1, rd2}, 0);
        chk("add_e1_ctrl", {26'd0, dp_ctrl}, 6'b000001);
        tick();
        chk("add_e2_ctrl", {26'd0, dp_ctrl}, 0);
        chk("add_e2_wr", {31'd0, wr1}, 1);
        chk("add_e2_wraddr", {28'd0, wr_addr}, 3);
        tick();
        chk("add_e3_wr", {31'd0, wr1}, 0);
        chk("add_e3_ready", {31'd0, inst_ready}, 1);
        chk("add_e3_cnt", {16'd0, retire_cnt}, 1);

        // AND_LSB then LOAD_IN back to back
        inst       = 16'h4A56;
        inst_valid = 1'b1;
        tick();
        inst = 16'h5700;
        chk("and_e0_rd", {30'd0, rd1, rd2}, 2'b11);
        chk("and_e0_addr", {24'd0, addr1, addr2}, 8'h56);
        tick();
        chk("and_e1_ctrl", {26'd0, dp_ctrl}, 6'b001000);
        chk("and_e1_ready", {31'd0, inst_ready}, 0);
        tick();
        chk("and_e2_wr", {31'd0, wr1}, 1);
        chk("and_e2_wraddr", {28'd0, wr_addr}, 4'hA);
        tick();
        chk("and_e3_ready", {31'd0, inst_ready}, 1);
        chk("and_e3_cnt", {16'd0, retire_cnt}, 2);
        tick();
        inst_valid = 1'b0;
        chk("ld_e4_accept", {31'd0, inst_ready}, 0);
        chk("ld_e0_rd", {30'd0, rd1, rd2}, 0);
        tick();
        chk("ld_e1_ctrl", {26'd0, dp_ctrl}, 6'b010000);
        tick();
        chk("ld_e2_wr", {31'd0, wr1}, 1);
        chk("ld_e2_wraddr", {28'd0, wr_addr}, 7);
        tick();
        chk("ld_e3_cnt", {16'd0, retire_cnt}, 3);

        // STORE_OUT r9
        inst       = 16'h6090;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        chk("st_e0_rd", {30'd0, rd1, rd2}, 2'b10);
        chk("st_e0_addr1", {28'd0, addr1}, 9);
        tick();
        chk("st_e1_ctrl", {26'd0, dp_ctrl}, 6'b100000);
        chk("st_e1_wr", {31'd0, wr1}, 0);
        tick();
        chk("st_e2_wr", {31'd0, wr1}, 0);
        chk("st_e2_ctrl", {26'd0, dp_ctrl}, 0);
        tick();
        chk("st_e3_wr", {31'd0, wr1}, 0);
        chk("st_e3_cnt", {16'd0, retire_cnt}, 4);

        // illegal opcode 0x9, then ADD r4 = r4 + r5
        inst       = 16'h9123;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        chk("ill_e0_rd", {30'd0, rd1, rd2}, 0);
        chk("ill_e0_flag", {31'd0, illegal}, 0);
        tick();
        chk("ill_e1_flag", {31'd0, illegal}, 1);
        chk("ill_e1_ctrl", {26'd0, dp_ctrl}, 0);
        tick();
        chk("ill_e2_wr", {31'd0, wr1}, 0);
        tick();
        chk("ill_e3_cnt", {16'd0, retire_cnt}, 5);
        inst       = 16'h1445;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        chk("add2_e0_addr", {24'd0, addr1, addr2}, 8'h45);
        tick();
        chk("add2_e1_ctrl", {26'd0, dp_ctrl}, 6'b000001);
        chk("add2_e1_ill", {31'd0, illegal}, 1);
        tick();
        chk("add2_e2_wr", {27'd0, wr1, wr_addr}, 5'h14);
        tick();
        chk("add2_e3_cnt", {16'd0, retire_cnt}, 6);

        // HALT, then a held ADD that must never be taken
        inst       = 16'hF000;
        inst_valid = 1'b1;
        tick();
        inst = 16'h1312;
        chk("halt_e0_rd", {30'd0, rd1, rd2}, 0);
        tick();
        chk("halt_e1_flag", {31'd0, halted}, 1);
        chk("halt_e1_cnt", {16'd0, retire_cnt}, 7);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_stuck_ready", {31'd0, inst_ready}, 0);
            chk("halt_stuck_flag", {30'd0, halted, rd1}, 2'b10);
        end
        rst_n = 1'b0;
        tick();
        chk_all_zero("halt_reset");
        rst_n = 1'b1;
        tick();
        chk("post_halt_ready", {31'd0, inst_ready}, 1);
        tick();
        inst_valid = 1'b0;
        chk("post_halt_accept", {31'd0, inst_ready}, 0);
        chk("post_halt_rd", {30'd0, rd1, rd2}, 2'b11);
        tick();
        tick();
        tick();
        chk("post_halt_cnt", {16'd0, retire_cnt}, 1);

        // reset during EXEC of an ADD
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        chk("rx_e1_ctrl", {26'd0, dp_ctrl}, 6'b000001);
        rst_n = 1'b0;
        tick();
        chk_all_zero("rx_reset");
        rst_n = 1'b1;
        tick();
        chk("rx_ready", {31'd0, inst_ready}, 1);
        chk("rx_wr_a", {31'd0, wr1}, 0);
        tick();
        chk("rx_wr_b", {31'd0, wr1}, 0);
        chk("rx_cnt", {16'd0, retire_cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Control-side counterpart of the Datapath. Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Sequences each instruction through register-read, execute and write-back. Drives the Datapath's one-hot dp_ctrl and the register-file address, read-enable and write-enable strobes.
- Sits between the instruction source and the Datapath plus register file.

Parameters:
- INST_W, 16, instruction width.
- RADDR_W, 4, register-file address width.
- CTRL_W, 6, dp_ctrl width (one-hot).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- inst  in  INST_W  instruction word
- inst_valid  in  1  inst is valid
- inst_ready  out  1  sequencer can accept inst
- dp_ctrl  out  CTRL_W  one-hot Datapath operation select
- addr1  out  RADDR_W  register-file read port 1 address
- addr2  out  RADDR_W  register-file read port 2 address
- rd1  out  1  read enable, port 1
- rd2  out  1  read enable, port 2
- wr_addr  out  RADDR_W  register-file write address
- wr1  out  1  register-file write enable (captures Datapath wr_data)
- halted  out  1  HALT retired; sequencer stopped
- illegal  out  1  sticky: an illegal opcode was seen
- retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- All outputs are registered. rst_n sampled low at a clk edge sets state IDLE and drives every output to 0, including inst_ready, illegal and retire_cnt.
- inst_ready rises at the first edge with rst_n high.
- Encoding: inst[15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- Opcodes and dp_ctrl:
  - 0x0 NOP, dp_ctrl 000000
  - 0x1 ADD, 000001
  - 0x2 R_SHIFT, 000010
  - 0x3 L_SHIFT, 000100
  - 0x4 AND_LSB, 001000
  - 0x5 LOAD_IN, 010000 (in_bus to wr_data)
  - 0x6 STORE_OUT, 100000 (rs1 to out_bus)
  - 0xF HALT, 000000
  - All others illegal.
- Operand use:
  - ADD, R_SHIFT, L_SHIFT, AND_LSB: read rs1 and rs2; write rd.
  - LOAD_IN: no read; write rd.
  - STORE_OUT: read rs1 only; no write.
  - NOP, HALT, illegal: no read, no write.
- FSM states: IDLE, READ, EXEC, WB, HALTED.
- Handshake: transfer occurs at edge E0 when inst_valid and inst_ready are both high. inst is latched. inst_valid with inst_ready low is ignored; the source must hold it.
- Edge E0: IDLE -> READ. inst_ready<=0. addr1<=rs1, addr2<=rs2. rd1/rd2<=1 per operand use.
- Edge E1: READ -> EXEC, or READ -> HALTED for HALT. rd1/rd2<=0. dp_ctrl<=decoded value. Illegal opcode sets illegal<=1 and the instruction then proceeds as NOP.
- Edge E2: EXEC -> WB. dp_ctrl<=0. wr_addr<=rd. wr1<=1 if the op writes.
- Edge E3: WB -> IDLE. wr1<=0. inst_ready<=1. retire_cnt increments.
- Cycle timing:
  - rd strobes are high for exactly one cycle. Register data is valid while dp_ctrl is asserted.
  - dp_ctrl is high for exactly one cycle. wr1 is high for exactly one cycle.
  - Next acceptance can occur at E4 at the earliest. Throughput is 1 instruction per 4 cycles.
- HALT at E1: halted<=1, retire_cnt increments, inst_ready stays 0. HALTED is exited only by reset.
- addr1, addr2 and wr_addr hold their last values when not strobed.
- retire_cnt wraps from 2^CNT_W-1 to 0 silently.
- illegal is sticky until reset; it does not stop execution.
- Reset in any state, including mid-instruction: the in-flight instruction is abandoned. No wr1 pulse is issued after the reset edge, and retire_cnt is not incremented for it.

Test Plan:
- Reset, then rst_n high, then ADD inst=0x1312 with inst_valid held -> accepted at the first edge with inst_ready high. Next cycle: rd1=rd2=1, addr1=1, addr2=2. Next cycle: dp_ctrl=000001. Next cycle: wr1=1, wr_addr=3. Next cycle: inst_ready=1, retire_cnt=1.
- Back-to-back AND_LSB 0x4A56 then LOAD_IN 0x5700, valid held continuously -> second acceptance exactly 4 cycles after the first. LOAD_IN gives rd1=rd2=0, dp_ctrl=010000, wr1=1, wr_addr=7.
- STORE_OUT 0x6090 -> rd1=1, rd2=0, addr1=9, dp_ctrl=100000, wr1 never asserted, retire_cnt increments.
- Opcode 0x9 (inst=0x9123) -> illegal=1 one cycle after acceptance, dp_ctrl stays 0, no rd or wr strobes, retires. A following ADD executes normally with illegal still 1.
- HALT 0xF000, then valid ADD held -> halted=1, retire_cnt+1, inst_ready remains 0 for 20 cycles. After a reset pulse: halted=0, retire_cnt=0, ADD then accepted.
- rst_n low in the EXEC cycle of an ADD -> all outputs 0 after that edge, no wr1 pulse, retire_cnt unchanged at 0. inst_ready=1 one edge after rst_n is released.
